// File: rtl/cmp_result_monitor_if.sv
// Sample/result bundle between the comparator and its checker/statistics stage.
interface cmp_result_monitor_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  // in_valid qualifies a/b/gt/lt/eq for exactly one cycle. There is no ready:
  // every valid sample is consumed. Result pulses are single-cycle strobes.
  logic             clear;
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             gt;
  logic             lt;
  logic             eq;

  logic             stat_valid;
  logic [CNT_W-1:0] stat_gt;
  logic [CNT_W-1:0] stat_lt;
  logic [CNT_W-1:0] stat_eq;
  logic             cross_valid;
  logic [WIDTH-1:0] cross_a;
  logic [WIDTH-1:0] cross_b;
  logic             cross_dir;
  logic             err;
  logic [7:0]       err_count;

  modport master (
    output clear, in_valid, a, b, gt, lt, eq,
    input  stat_valid, stat_gt, stat_lt, stat_eq,
    input  cross_valid, cross_a, cross_b, cross_dir, err, err_count
  );

  modport slave (
    input  clear, in_valid, a, b, gt, lt, eq,
    output stat_valid, stat_gt, stat_lt, stat_eq,
    output cross_valid, cross_a, cross_b, cross_dir, err, err_count
  );
endinterface

// File: rtl/cmp_result_monitor.sv
// Checker/statistics stage behind the magnitude comparator: flag verification,
// windowed outcome counts and lt/gt crossover capture.
module cmp_result_monitor #(
  parameter int WIDTH   = 32,
  parameter int WIN_LEN = 256,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                reset,
  cmp_result_monitor_if.slave mon,
  output logic [1:0]          dbg_state
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIN_LEN - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] sample_cnt;
  logic [CNT_W-1:0] acc_gt;
  logic [CNT_W-1:0] acc_lt;
  logic [CNT_W-1:0] acc_eq;
  logic [CNT_W-1:0] tot_gt;
  logic [CNT_W-1:0] tot_lt;
  logic [CNT_W-1:0] tot_eq;
  logic             dir_valid;
  logic             dir_gt;
  logic [2:0]       ref_flags;
  logic             sample_err;
  logic             sample_ok;
  logic             win_done;
  logic             cross_hit;

  assign ref_flags  = {mon.a > mon.b, mon.a < mon.b, mon.a == mon.b};
  assign sample_err = mon.in_valid && ({mon.gt, mon.lt, mon.eq} != ref_flags);
  assign sample_ok  = mon.in_valid && !sample_err;
  assign win_done   = mon.in_valid && (sample_cnt == LAST_IDX);
  assign cross_hit  = sample_ok && dir_valid &&
                      ((mon.gt && !dir_gt) || (mon.lt && dir_gt));

  // Totals including the current sample, so a closing sample lands in its window.
  assign tot_gt = acc_gt + CNT_W'(sample_ok && mon.gt);
  assign tot_lt = acc_lt + CNT_W'(sample_ok && mon.lt);
  assign tot_eq = acc_eq + CNT_W'(sample_ok && mon.eq);

  assign dbg_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mon.in_valid) state_nxt = ACCUM;
      ACCUM:   if (win_done) state_nxt = REPORT;
      REPORT:  state_nxt = ACCUM;
      default: state_nxt = IDLE;
    endcase
    if (mon.clear) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_cnt      <= '0;
      acc_gt          <= '0;
      acc_lt          <= '0;
      acc_eq          <= '0;
      dir_valid       <= 1'b0;
      dir_gt          <= 1'b0;
      mon.stat_valid  <= 1'b0;
      mon.stat_gt     <= '0;
      mon.stat_lt     <= '0;
      mon.stat_eq     <= '0;
      mon.cross_valid <= 1'b0;
      mon.cross_a     <= '0;
      mon.cross_b     <= '0;
      mon.cross_dir   <= 1'b0;
      mon.err         <= 1'b0;
      mon.err_count   <= '0;
    end else if (mon.clear) begin
      sample_cnt      <= '0;
      acc_gt          <= '0;
      acc_lt          <= '0;
      acc_eq          <= '0;
      dir_valid       <= 1'b0;
      dir_gt          <= 1'b0;
      mon.stat_valid  <= 1'b0;
      mon.stat_gt     <= '0;
      mon.stat_lt     <= '0;
      mon.stat_eq     <= '0;
      mon.cross_valid <= 1'b0;
      mon.cross_a     <= '0;
      mon.cross_b     <= '0;
      mon.cross_dir   <= 1'b0;
      mon.err         <= 1'b0;
      mon.err_count   <= '0;
    end else begin
      mon.stat_valid  <= win_done;
      mon.cross_valid <= cross_hit;
      if (mon.in_valid) begin
        if (win_done) begin
          sample_cnt  <= '0;
          acc_gt      <= '0;
          acc_lt      <= '0;
          acc_eq      <= '0;
          mon.stat_gt <= tot_gt;
          mon.stat_lt <= tot_lt;
          mon.stat_eq <= tot_eq;
        end else begin
          sample_cnt <= sample_cnt + 1'b1;
          acc_gt     <= tot_gt;
          acc_lt     <= tot_lt;
          acc_eq     <= tot_eq;
        end
      end
      if (sample_err) begin
        mon.err <= 1'b1;
        if (mon.err_count != 8'hFF) mon.err_count <= mon.err_count + 8'd1;
      end
      // Equal samples bridge a crossover: only clean gt/lt samples move last_dir.
      if (sample_ok && (mon.gt || mon.lt)) begin
        dir_valid <= 1'b1;
        dir_gt    <= mon.gt;
      end
      if (cross_hit) begin
        mon.cross_a   <= mon.a;
        mon.cross_b   <= mon.b;
        mon.cross_dir <= mon.gt;
      end
    end
  end
endmodule
